// File: rtl/dsi_phy_pkg.sv
// Shared definitions for the D-PHY HS lane sequencing logic.
package dsi_phy_pkg;

    localparam int LANES_MAX = 4;
    localparam int TIM_W     = 8;

    localparam logic [TIM_W-1:0] TIM_ONE = TIM_W'(1);

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_CLK_START   = 4'd1,
        ST_CLK_PRE     = 4'd2,
        ST_IDLE_CLK    = 4'd3,
        ST_DATA_START  = 4'd4,
        ST_DATA_ACTIVE = 4'd5,
        ST_DATA_TRAIL  = 4'd6,
        ST_CLK_POST    = 4'd7,
        ST_CLK_TRAIL   = 4'd8,
        ST_DONE        = 4'd9
    } hs_state_e;

    // Counter preload for a cycle count; 0 is treated as 1 so the counter never wraps.
    function automatic logic [TIM_W-1:0] tim_load(input logic [TIM_W-1:0] cfg);
        return (cfg == '0) ? '0 : (cfg - TIM_ONE);
    endfunction

endpackage

// File: rtl/dphy_tim_cnt.sv
// Load / saturating decrement / zero-flag timer used for the clk-pre and clk-post gaps.
module dphy_tim_cnt
    import dsi_phy_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TIM_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [TIM_W-1:0] cnt_q;
    logic [TIM_W-1:0] cnt_d;

    // Next count: load has priority; decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - TIM_ONE;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/dphy_hs_lanes_ctrl.sv
// Sequences the HS clock lane and the enabled HS data lanes for each burst.
//
// state          | meaning
// ST_IDLE        | clock lane stopped, no burst
// ST_CLK_START   | one-cycle start request to the clock lane
// ST_CLK_PRE     | waiting clk-pre cycles before data lanes start
// ST_IDLE_CLK    | clock lane running in HS, no burst
// ST_DATA_START  | one-cycle start request to enabled data lanes
// ST_DATA_ACTIVE | bytes flowing; upstream fin forwarded to lanes
// ST_DATA_TRAIL  | collecting fin_acks from all enabled lanes
// ST_CLK_POST    | waiting clk-post cycles before stopping the clock lane
// ST_CLK_TRAIL   | clock lane fin request held until acknowledged
// ST_DONE        | one-cycle burst-complete pulse
module dphy_hs_lanes_ctrl
    import dsi_phy_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cfg_lanes_num,
    input  logic [TIM_W-1:0] cfg_clk_pre,
    input  logic [TIM_W-1:0] cfg_clk_post,
    input  logic             cfg_clk_cont,
    input  logic             hs_start_rqst,
    input  logic             hs_fin_rqst,
    output logic             hs_data_rqst,
    output logic             hs_busy,
    output logic             hs_done,
    output logic             clk_lane_start,
    output logic             clk_lane_fin,
    input  logic             clk_lane_fin_ack,
    output logic [LANES-1:0] dl_start,
    output logic [LANES-1:0] dl_fin,
    input  logic [LANES-1:0] dl_data_rqst,
    input  logic [LANES-1:0] dl_fin_ack
);

    hs_state_e        state_q, state_d;
    logic [LANES-1:0] en_q, en_d;
    logic [LANES-1:0] ack_q, ack_d;
    logic             pend_q, pend_d;
    logic             clk_run_q, clk_run_d;

    logic [LANES-1:0] en_cfg;
    logic             ack_all;
    logic             pre_load, pre_dec, pre_zero;
    logic             post_load, post_dec, post_zero;
    logic             unused_data_rqst;

    // Only lane 0 paces upstream; the other strobes are identical copies.
    assign unused_data_rqst = ^dl_data_rqst;

    // Enable mask from the configured lane count; lanes above LANES do not exist.
    always_comb begin
        en_cfg = '0;
        for (int i = 0; i < LANES; i++) begin
            en_cfg[i] = (i <= int'(cfg_lanes_num));
        end
    end

    assign ack_all = (((ack_q | dl_fin_ack) & en_q) == en_q);

    dphy_tim_cnt u_pre_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (pre_load),
        .load_val (tim_load(cfg_clk_pre)),
        .dec      (pre_dec),
        .zero     (pre_zero)
    );

    dphy_tim_cnt u_post_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (post_load),
        .load_val (tim_load(cfg_clk_post)),
        .dec      (post_dec),
        .zero     (post_zero)
    );

    // Next-state and output decode from the registered state.
    always_comb begin
        state_d        = state_q;
        en_d           = en_q;
        ack_d          = ack_q;
        pend_d         = pend_q;
        clk_run_d      = clk_run_q;
        pre_load       = 1'b0;
        pre_dec        = 1'b0;
        post_load      = 1'b0;
        post_dec       = 1'b0;
        hs_data_rqst   = 1'b0;
        hs_busy        = 1'b1;
        hs_done        = 1'b0;
        clk_lane_start = 1'b0;
        clk_lane_fin   = 1'b0;
        dl_start       = '0;
        dl_fin         = '0;
        unique case (state_q)
            ST_IDLE: begin
                hs_busy = 1'b0;
                en_d    = en_cfg;
                if (hs_start_rqst || cfg_clk_cont) begin
                    pend_d  = hs_start_rqst;
                    state_d = ST_CLK_START;
                end
            end
            ST_CLK_START: begin
                clk_lane_start = 1'b1;
                clk_run_d      = 1'b1;
                pre_load       = 1'b1;
                state_d        = ST_CLK_PRE;
            end
            ST_CLK_PRE: begin
                if (pre_zero) begin
                    state_d = (pend_q || hs_start_rqst) ? ST_DATA_START : ST_IDLE_CLK;
                end else begin
                    pre_dec = 1'b1;
                end
            end
            ST_IDLE_CLK: begin
                hs_busy = 1'b0;
                en_d    = en_cfg;
                if (hs_start_rqst) begin
                    state_d = ST_DATA_START;
                end else if (!cfg_clk_cont) begin
                    post_load = 1'b1;
                    state_d   = ST_CLK_POST;
                end
            end
            ST_DATA_START: begin
                dl_start = en_q;
                ack_d    = '0;
                pend_d   = 1'b0;
                state_d  = ST_DATA_ACTIVE;
            end
            ST_DATA_ACTIVE: begin
                dl_fin       = en_q & {LANES{hs_fin_rqst}};
                hs_data_rqst = dl_data_rqst[0];
                if (hs_fin_rqst) begin
                    state_d = ST_DATA_TRAIL;
                end
            end
            ST_DATA_TRAIL: begin
                ack_d = ack_q | (dl_fin_ack & en_q);
                if (ack_all) begin
                    if (cfg_clk_cont) begin
                        state_d = ST_DONE;
                    end else begin
                        post_load = 1'b1;
                        state_d   = ST_CLK_POST;
                    end
                end
            end
            ST_CLK_POST: begin
                if (post_zero) begin
                    state_d = ST_CLK_TRAIL;
                end else begin
                    post_dec = 1'b1;
                end
            end
            ST_CLK_TRAIL: begin
                clk_lane_fin = 1'b1;
                if (clk_lane_fin_ack) begin
                    clk_run_d = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                hs_done = 1'b1;
                state_d = clk_run_q ? ST_IDLE_CLK : ST_IDLE;
            end
            default: begin
                hs_busy = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, enable mask, ack latches and burst bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            en_q      <= '0;
            ack_q     <= '0;
            pend_q    <= 1'b0;
            clk_run_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            ack_q     <= ack_d;
            pend_q    <= pend_d;
            clk_run_q <= clk_run_d;
        end
    end

endmodule

// File: tb/tb_dphy_hs_lanes_ctrl.sv
// Scoreboard bench for dphy_hs_lanes_ctrl: stimulus queues expected output events,
// a negedge monitor pops and compares each event the DUT presents.
module tb_dphy_hs_lanes_ctrl;

    localparam int LANES = 4;
    localparam int EV_CLK_START = 0;
    localparam int EV_DL_START  = 1;
    localparam int EV_DL_FIN    = 2;
    localparam int EV_CLK_FIN   = 3;
    localparam int EV_DONE      = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       cfg_lanes_num;
    logic [7:0]       cfg_clk_pre;
    logic [7:0]       cfg_clk_post;
    logic             cfg_clk_cont;
    logic             hs_start_rqst;
    logic             hs_fin_rqst;
    logic             hs_data_rqst;
    logic             hs_busy;
    logic             hs_done;
    logic             clk_lane_start;
    logic             clk_lane_fin;
    logic             clk_lane_fin_ack;
    logic [LANES-1:0] dl_start;
    logic [LANES-1:0] dl_fin;
    logic [LANES-1:0] dl_data_rqst;
    logic [LANES-1:0] dl_fin_ack;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_err    = 0;
    bit   mon_en   = 1'b0;
    logic fin_prev = 1'b0;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;
    ev_t sb[$];

    dphy_hs_lanes_ctrl #(.LANES(LANES)) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_lanes_num    (cfg_lanes_num),
        .cfg_clk_pre      (cfg_clk_pre),
        .cfg_clk_post     (cfg_clk_post),
        .cfg_clk_cont     (cfg_clk_cont),
        .hs_start_rqst    (hs_start_rqst),
        .hs_fin_rqst      (hs_fin_rqst),
        .hs_data_rqst     (hs_data_rqst),
        .hs_busy          (hs_busy),
        .hs_done          (hs_done),
        .clk_lane_start   (clk_lane_start),
        .clk_lane_fin     (clk_lane_fin),
        .clk_lane_fin_ack (clk_lane_fin_ack),
        .dl_start         (dl_start),
        .dl_fin           (dl_fin),
        .dl_data_rqst     (dl_data_rqst),
        .dl_fin_ack       (dl_fin_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int c, input int v);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input int v);
        ev_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
        end else begin
            e = sb.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_cycle", cyc, e.cyc);
            check("ev_value", v, e.val);
        end
    endtask

    // Advance to a point 1 time unit after the posedge that starts cycle t.
    task automatic at_cycle(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // Monitor: every output event the DUT presents is matched against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (clk_lane_start)             pop_cmp(EV_CLK_START, 0);
            if (dl_start != '0)             pop_cmp(EV_DL_START, int'(dl_start));
            if (dl_fin != '0)               pop_cmp(EV_DL_FIN, int'(dl_fin));
            if (clk_lane_fin && !fin_prev)  pop_cmp(EV_CLK_FIN, 0);
            if (hs_done)                    pop_cmp(EV_DONE, 0);
        end
        fin_prev <= clk_lane_fin;
    end

    // One HS burst. clk_on: clock lane already running (ST_IDLE_CLK);
    // keep: continuous clock stays on at the end; early_fin: fin held before data phase.
    task automatic burst(input int nbytes, input int s0, input int s1, input int s2,
                         input int s3, input bit clk_on, input bit keep, input bit early_fin);
        int n, ds, f, a, cf, k, en, p, q, mx;
        int sk[4];
        sk[0] = s0; sk[1] = s1; sk[2] = s2; sk[3] = s3;
        n  = cyc;
        en = (1 << (int'(cfg_lanes_num) + 1)) - 1;
        p  = eff(int'(cfg_clk_pre));
        q  = eff(int'(cfg_clk_post));
        mx = 0;
        for (int i = 0; i < 4; i++) if (en[i] && sk[i] > mx) mx = sk[i];
        if (clk_on) begin
            ds = n + 1;
        end else begin
            ds = n + 2 + p;
            expect_ev(EV_CLK_START, n + 1, 0);
        end
        expect_ev(EV_DL_START, ds, en);
        f = ds + nbytes;
        expect_ev(EV_DL_FIN, f, en);
        a = f + 1 + mx;
        cf = a + 1 + q;
        k  = cf + 2;
        if (keep) begin
            expect_ev(EV_DONE, a + 1, 0);
        end else begin
            expect_ev(EV_CLK_FIN, cf, 0);
            expect_ev(EV_DONE, k + 1, 0);
        end
        hs_start_rqst = 1'b1;
        hs_fin_rqst   = early_fin;
        at_cycle(ds);
        hs_start_rqst = 1'b0;
        hs_fin_rqst   = 1'b0;
        check("busy_in_burst", hs_busy, 1);
        check("data_rqst_gated", hs_data_rqst, 0);
        at_cycle(ds + 1);
        check("data_rqst_fwd", hs_data_rqst, 1);
        at_cycle(f);
        hs_fin_rqst = 1'b1;
        at_cycle(f + 1);
        hs_fin_rqst = 1'b0;
        for (int c = f + 1; c <= a; c++) begin
            at_cycle(c);
            for (int i = 0; i < 4; i++) dl_fin_ack[i] = (c == f + 1 + sk[i]);
        end
        at_cycle(a + 1);
        dl_fin_ack = '0;
        if (keep) begin
            at_cycle(a + 2);
            check("busy_idle_clk", hs_busy, 0);
        end else begin
            at_cycle(k);
            clk_lane_fin_ack = 1'b1;
            at_cycle(k + 1);
            clk_lane_fin_ack = 1'b0;
            at_cycle(k + 2);
            check("busy_idle", hs_busy, 0);
        end
    endtask

    initial begin
        #100000;
        n_err++;
        $display("FAIL timeout: got no end expected end before 100000 time units");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        int n, c;
        rst = 1'b1;
        cfg_lanes_num = 2'd0;
        cfg_clk_pre = 8'd3;
        cfg_clk_post = 8'd2;
        cfg_clk_cont = 1'b0;
        hs_start_rqst = 1'b0;
        hs_fin_rqst = 1'b0;
        clk_lane_fin_ack = 1'b0;
        dl_data_rqst = '1;
        dl_fin_ack = '0;
        at_cycle(3);
        check("rst_clk_lane_start", clk_lane_start, 0);
        check("rst_clk_lane_fin", clk_lane_fin, 0);
        check("rst_dl_start", dl_start, 0);
        check("rst_dl_fin", dl_fin, 0);
        check("rst_busy", hs_busy, 0);
        check("rst_done", hs_done, 0);
        check("rst_data_rqst", hs_data_rqst, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        at_cycle(4);

        // 1 lane, pre=3, post=2, 4 bytes
        cfg_lanes_num = 2'd0; cfg_clk_pre = 8'd3; cfg_clk_post = 8'd2;
        burst(4, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        // 4 lanes, skewed fin_acks
        cfg_lanes_num = 2'd3; cfg_clk_pre = 8'd2; cfg_clk_post = 8'd3;
        burst(3, 0, 1, 3, 5, 1'b0, 1'b0, 1'b0);

        // pre=0/post=0 behave as 1; early fin ignored; 1-byte burst
        cfg_lanes_num = 2'd1; cfg_clk_pre = 8'd0; cfg_clk_post = 8'd0;
        burst(1, 2, 0, 0, 0, 1'b0, 1'b0, 1'b1);

        // continuous clock: warm-up, two bursts, then release
        cfg_lanes_num = 2'd2; cfg_clk_pre = 8'd2; cfg_clk_post = 8'd2;
        n = cyc;
        cfg_clk_cont = 1'b1;
        expect_ev(EV_CLK_START, n + 1, 0);
        at_cycle(n + 4);
        check("busy_warm_idle_clk", hs_busy, 0);
        burst(2, 0, 1, 0, 0, 1'b1, 1'b1, 1'b0);
        burst(3, 1, 0, 2, 0, 1'b1, 1'b1, 1'b0);
        c = cyc;
        cfg_clk_cont = 1'b0;
        expect_ev(EV_CLK_FIN, c + 3, 0);
        expect_ev(EV_DONE, c + 6, 0);
        at_cycle(c + 5);
        clk_lane_fin_ack = 1'b1;
        at_cycle(c + 6);
        clk_lane_fin_ack = 1'b0;
        at_cycle(c + 7);
        check("busy_after_cont", hs_busy, 0);

        // reset in ST_DATA_ACTIVE, then a normal burst
        cfg_lanes_num = 2'd1; cfg_clk_pre = 8'd1; cfg_clk_post = 8'd1;
        n = cyc;
        expect_ev(EV_CLK_START, n + 1, 0);
        expect_ev(EV_DL_START, n + 3, 3);
        hs_start_rqst = 1'b1;
        at_cycle(n + 3);
        hs_start_rqst = 1'b0;
        at_cycle(n + 5);
        check("pre_rst_data_rqst", hs_data_rqst, 1);
        rst = 1'b1;
        at_cycle(n + 6);
        rst = 1'b0;
        check("mid_rst_data_rqst", hs_data_rqst, 0);
        check("mid_rst_busy", hs_busy, 0);
        check("mid_rst_dl_fin", dl_fin, 0);
        check("mid_rst_clk_fin", clk_lane_fin, 0);
        burst(2, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        at_cycle(cyc + 3);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
